// File: rtl/uart_prog_loader.sv
// UART boot loader: 8N1 receiver feeding a word assembler that drives the memory programming port.
// Latency: upg_wen is asserted 2 clk after the stop-bit sample of a word's 4th byte.
// Backpressure: none; the serial stream is consumed at line rate and writes are never stalled.
module uart_prog_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DEPTH        = 16384,
   parameter int TIMEOUT_CLKS = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic        upg_wen,
   output logic [13:0] upg_adr,
   output logic [31:0] upg_dat,
   output logic        upg_done,
   output logic        busy,
   output logic        frame_err
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
   localparam logic [16:0]      DEPTH_V   = 17'(DEPTH);

   typedef enum logic [1:0] {
      BIT_IDLE,
      BIT_START,
      BIT_DATA,
      BIT_STOP
   } bit_state_t;

   typedef enum logic [1:0] {
      WAIT_LEN0,
      WAIT_LEN1,
      LOAD_DATA,
      LOAD_DONE
   } load_state_t;

   // receiver side
   logic             rx_meta;
   logic             rx_s;
   logic             rx_prev;
   bit_state_t       bit_state;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic             byte_valid;
   logic             stop_err;

   // loader side
   load_state_t      load_state;
   logic [15:0]      n_words;
   logic [15:0]      n_new;
   logic [15:0]      word_idx;
   logic [1:0]       byte_idx;
   logic [31:0]      word_buf;
   logic [TO_W-1:0]  idle_cnt;

   // the full count is only complete once the high byte is on shreg
   assign n_new = {shreg, n_words[7:0]};

   // two-flop synchronizer plus a delayed copy for falling-edge detection; idles high
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // bit-level receiver: half-bit start check, 8 LSB-first data samples, one stop sample
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_state  <= BIT_IDLE;
         clk_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         stop_err   <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         stop_err   <= 1'b0;
         case (bit_state)
            BIT_IDLE: begin
               clk_cnt <= '0;
               bit_cnt <= '0;
               if (rx_prev && !rx_s) begin
                  bit_state <= BIT_START;
               end
            end
            BIT_START: begin
               if (clk_cnt == HALF_LAST) begin
                  clk_cnt   <= '0;
                  // a line that is already high again was only a glitch
                  bit_state <= rx_s ? BIT_IDLE : BIT_DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            BIT_DATA: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  if (bit_cnt == 3'd7) begin
                     bit_state <= BIT_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            BIT_STOP: begin
               if (clk_cnt == BIT_LAST) begin
                  clk_cnt   <= '0;
                  bit_state <= BIT_IDLE;
                  if (rx_s) begin
                     byte_valid <= 1'b1;
                  end else begin
                     stop_err <= 1'b1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: bit_state <= BIT_IDLE;
         endcase
      end
   end

   // load sequencer: count header, word assembly and write strobe, completion and inter-byte timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         load_state <= WAIT_LEN0;
         n_words    <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         word_buf   <= '0;
         idle_cnt   <= '0;
         upg_wen    <= 1'b0;
         upg_adr    <= '0;
         upg_dat    <= '0;
         upg_done   <= 1'b0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         upg_wen <= 1'b0;

         // once finished, the line is ignored entirely, including bad frames
         if (stop_err && load_state != LOAD_DONE) begin
            frame_err <= 1'b1;
         end

         if (byte_valid) begin
            case (load_state)
               WAIT_LEN0: begin
                  n_words[7:0] <= shreg;
                  busy         <= 1'b1;
                  load_state   <= WAIT_LEN1;
               end
               WAIT_LEN1: begin
                  n_words <= n_new;
                  if (n_new == 16'd0) begin
                     upg_done   <= 1'b1;
                     busy       <= 1'b0;
                     load_state <= LOAD_DONE;
                  end else if ({1'b0, n_new} > DEPTH_V) begin
                     frame_err  <= 1'b1;
                     busy       <= 1'b0;
                     load_state <= WAIT_LEN0;
                  end else begin
                     word_idx   <= '0;
                     byte_idx   <= '0;
                     load_state <= LOAD_DATA;
                  end
               end
               LOAD_DATA: begin
                  // bytes enter at the top so the first byte lands in [7:0] after four shifts
                  word_buf <= {shreg, word_buf[31:8]};
                  if (byte_idx == 2'd3) begin
                     byte_idx <= '0;
                     upg_wen  <= 1'b1;
                     upg_adr  <= word_idx[13:0];
                     upg_dat  <= {shreg, word_buf[31:8]};
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
               default: ;
            endcase
         end

         // the index advances in the strobe cycle, so completion shows one cycle after the write
         if (upg_wen) begin
            word_idx <= word_idx + 16'd1;
            if (word_idx + 16'd1 == n_words) begin
               upg_done   <= 1'b1;
               busy       <= 1'b0;
               load_state <= LOAD_DONE;
            end
         end

         if (!busy || byte_valid) begin
            idle_cnt <= '0;
         end else if (idle_cnt == TO_LAST) begin
            // abandon the partial image; the host restarts from the count header
            idle_cnt   <= '0;
            frame_err  <= 1'b1;
            busy       <= 1'b0;
            word_idx   <= '0;
            byte_idx   <= '0;
            load_state <= WAIT_LEN0;
         end else begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- UART boot-programming initiator: receives an 8N1 serial image, assembles little-endian 32-bit words and drives the upg_wen/upg_adr/upg_dat/upg_done write port of the instruction/data memories.
- Sits between the board RX pin and the memories' programming port. The top level ties each memory's upg_clk to this block's clk and its upg_rst to this block's busy.
- Frame format: 2-byte word count N (little-endian), followed by N×4 data bytes (little-endian words). Words are written to addresses 0..N-1.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4
DEPTH, 16384, maximum word count accepted; equals the 14-bit address space
TIMEOUT_CLKS, 1000000, idle clocks between bytes before an in-progress load aborts

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx  in  1  asynchronous serial input, idle high
upg_wen  out  1  one-cycle write strobe
upg_adr  out  14  word address of the current write
upg_dat  out  32  write data
upg_done  out  1  sticky; high once N words are written
busy  out  1  high from first count byte until done or abort
frame_err  out  1  sticky error: bad stop bit, count > DEPTH, or timeout

Behaviour:
- Reset values: all outputs 0, byte FSM IDLE, load FSM WAIT_LEN0, counters 0. Reset mid-load discards all partial state.
- rx passes through a 2-FF synchronizer before any use.
- Bit FSM:
  - IDLE: a synced rx falling edge moves to START.
  - START: at CLKS_PER_BIT/2, rx=1 is a false start and returns to IDLE; rx=0 moves to DATA.
  - DATA: 8 samples spaced CLKS_PER_BIT apart, LSB first.
  - STOP: one sample. rx=1 pulses byte_valid for one cycle. rx=0 discards the byte and sets frame_err.
- Load FSM (advances on byte_valid):
  - WAIT_LEN0: latch N[7:0], set busy, go to WAIT_LEN1.
  - WAIT_LEN1: latch N[15:8].
    - N=0: set upg_done, clear busy, go to DONE.
    - N>DEPTH: set frame_err, clear busy, go to WAIT_LEN0.
    - Otherwise: go to DATA.
  - DATA: shift bytes into a word, byte k into bits [8k+7:8k]. On the 4th byte, in the cycle after that byte's byte_valid:
    - upg_wen=1 for exactly 1 cycle, upg_adr=word index, upg_dat=assembled word.
    - Word index increments after the write.
    - If the index reaches N: upg_done=1 and busy=0 in the next cycle, go to DONE.
  - DONE: terminal; ignores all rx traffic until rst.
- upg_adr and upg_dat hold their last written values between strobes. Only upg_wen pulses.
- Timeout: an idle counter runs while busy=1 and clears on each byte_valid. Reaching TIMEOUT_CLKS sets frame_err, clears busy, the word index and the byte index, and returns to WAIT_LEN0.
- A framing error inside DATA does not advance the byte index, so the image shifts and the host must re-send after timeout. frame_err is never cleared except by rst.
- Latency: from mid-stop-bit sample of byte 4 to upg_wen is 2 clk.
- Address wrap is impossible, because N<=DEPTH is enforced.

Test Plan:
1. CLKS_PER_BIT=4; send 02 00 | 78 56 34 12 | EF BE AD DE -> upg_wen pulses twice: adr 0 dat 0x12345678, then adr 1 dat 0xDEADBEEF; upg_done=1, busy=0, frame_err=0.
2. Send 00 00 -> upg_done=1 with no upg_wen pulse; further bytes 11 22 33 44 produce no upg_wen.
3. 1-clk rx low glitch, then a valid load of N=1 word 0xA5A5A5A5 -> glitch ignored; single write adr 0 dat 0xA5A5A5A5.
4. Send 01 40 (N=16385) -> frame_err=1, busy=0, no write; then 01 00 + 4 bytes -> one write at adr 0, upg_done=1.
5. TIMEOUT_CLKS=200; send 01 00 AA BB then idle 300 clk -> frame_err=1, busy=0; then 01 00 01 02 03 04 -> adr 0 dat 0x04030201.
6. Assert rst for 1 clk mid-way through word 1 of an N=2 load -> all outputs 0; a fresh full N=2 load writes adr 0 and adr 1 correctly.
